// File: rtl/host_pcr_bridge.sv
// Host-to-PCR bridge: accepts one host request at a time, issues a single
// access strobe to the PCR file, waits READ_LAT cycles for read data, and
// holds the response until the host accepts it.
module host_pcr_bridge #(
    parameter int READ_LAT = 0,
    parameter int NUM_REGS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        io_req_valid,
    output logic        io_req_ready,
    input  logic        io_req_bits_rw,
    input  logic [4:0]  io_req_bits_addr,
    input  logic [63:0] io_req_bits_data,
    output logic        io_resp_valid,
    input  logic        io_resp_ready,
    output logic [63:0] io_resp_bits_data,
    output logic        io_resp_bits_err,
    output logic        io_pcr_en,
    output logic        io_pcr_wen,
    output logic [4:0]  io_pcr_addr,
    output logic [63:0] io_pcr_wdata,
    input  logic [63:0] io_pcr_rdata,
    output logic        io_busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    // Counter preload; unused when READ_LAT is 0 since ISSUE goes straight to RESP.
    localparam logic [2:0] LP_CNT_INIT = (READ_LAT > 0) ? 3'(READ_LAT - 1) : 3'd0;
    localparam logic [5:0] LP_NUM_REGS = 6'(NUM_REGS);

    state_t      r_state;
    state_t      w_next_state;
    logic [2:0]  r_cnt;
    logic        r_rw;
    logic [4:0]  r_addr;
    logic [63:0] r_wdata;
    logic [63:0] r_resp_data;
    logic        r_resp_err;
    logic        w_req_fire;
    logic        w_in_range;
    logic        w_capture;

    assign w_req_fire        = io_req_valid && io_req_ready;
    assign w_in_range        = ({1'b0, r_addr} < LP_NUM_REGS);
    assign io_busy           = (r_state != ST_IDLE);
    assign io_pcr_addr       = r_addr;
    assign io_pcr_wdata      = r_wdata;
    assign io_resp_bits_data = r_resp_data;
    assign io_resp_bits_err  = r_resp_err;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode, handshake outputs and PCR strobe
    always_comb begin
        w_next_state  = r_state;
        io_req_ready  = 1'b0;
        io_resp_valid = 1'b0;
        io_pcr_en     = 1'b0;
        io_pcr_wen    = 1'b0;
        w_capture     = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                io_req_ready = 1'b1;
                if (io_req_valid) begin
                    w_next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (w_in_range) begin
                    io_pcr_en  = 1'b1;
                    io_pcr_wen = r_rw;
                    if (READ_LAT == 0) begin
                        w_capture    = 1'b1;
                        w_next_state = ST_RESP;
                    end else begin
                        w_next_state = ST_WAIT;
                    end
                end else begin
                    w_next_state = ST_RESP;
                end
            end
            ST_WAIT: begin
                if (r_cnt == 3'd0) begin
                    w_capture    = 1'b1;
                    w_next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                io_resp_valid = 1'b1;
                if (io_resp_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Request latch: only updated on request fire so PCR addr/wdata stay stable
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rw    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_req_fire) begin
            r_rw    <= io_req_bits_rw;
            r_addr  <= io_req_bits_addr;
            r_wdata <= io_req_bits_data;
        end
    end

    // Read-latency counter: preloaded in ISSUE, counts down in WAIT
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (r_state == ST_ISSUE) begin
            r_cnt <= LP_CNT_INIT;
        end else if (r_state == ST_WAIT && r_cnt != 3'd0) begin
            r_cnt <= r_cnt - 3'd1;
        end
    end

    // Response register: ISSUE decides err and write echo; read data is
    // overwritten at the capture cycle, which is ISSUE itself when READ_LAT is 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_resp_data <= '0;
            r_resp_err  <= 1'b0;
        end else if (r_state == ST_ISSUE) begin
            if (!w_in_range) begin
                r_resp_data <= '0;
                r_resp_err  <= 1'b1;
            end else begin
                r_resp_err  <= 1'b0;
                r_resp_data <= (r_rw || !w_capture) ? r_wdata : io_pcr_rdata;
            end
        end else if (w_capture && !r_rw) begin
            r_resp_data <= io_pcr_rdata;
        end
    end

endmodule

// File: tb/tb_host_pcr_bridge.sv
// Self-checking bench for host_pcr_bridge: two instances (READ_LAT=0/NUM_REGS=32
// and READ_LAT=3/NUM_REGS=16) driven by directed and random transactions and
// compared against a transaction-level expectation of latency and response.
module tb_host_pcr_bridge;

    logic        clk = 1'b0;
    logic        rst        [2];
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        req_rw     [2];
    logic [4:0]  req_addr   [2];
    logic [63:0] req_data   [2];
    logic        resp_valid [2];
    logic        resp_ready [2];
    logic [63:0] resp_data  [2];
    logic        resp_err   [2];
    logic        pcr_en     [2];
    logic        pcr_wen    [2];
    logic [4:0]  pcr_addr   [2];
    logic [63:0] pcr_wdata  [2];
    logic [63:0] pcr_rdata  [2];
    logic        busy       [2];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    host_pcr_bridge #(.READ_LAT(0), .NUM_REGS(32)) dut0 (
        .clk(clk), .reset(rst[0]),
        .io_req_valid(req_valid[0]), .io_req_ready(req_ready[0]),
        .io_req_bits_rw(req_rw[0]), .io_req_bits_addr(req_addr[0]),
        .io_req_bits_data(req_data[0]),
        .io_resp_valid(resp_valid[0]), .io_resp_ready(resp_ready[0]),
        .io_resp_bits_data(resp_data[0]), .io_resp_bits_err(resp_err[0]),
        .io_pcr_en(pcr_en[0]), .io_pcr_wen(pcr_wen[0]),
        .io_pcr_addr(pcr_addr[0]), .io_pcr_wdata(pcr_wdata[0]),
        .io_pcr_rdata(pcr_rdata[0]), .io_busy(busy[0])
    );

    host_pcr_bridge #(.READ_LAT(3), .NUM_REGS(16)) dut1 (
        .clk(clk), .reset(rst[1]),
        .io_req_valid(req_valid[1]), .io_req_ready(req_ready[1]),
        .io_req_bits_rw(req_rw[1]), .io_req_bits_addr(req_addr[1]),
        .io_req_bits_data(req_data[1]),
        .io_resp_valid(resp_valid[1]), .io_resp_ready(resp_ready[1]),
        .io_resp_bits_data(resp_data[1]), .io_resp_bits_err(resp_err[1]),
        .io_pcr_en(pcr_en[1]), .io_pcr_wen(pcr_wen[1]),
        .io_pcr_addr(pcr_addr[1]), .io_pcr_wdata(pcr_wdata[1]),
        .io_pcr_rdata(pcr_rdata[1]), .io_busy(busy[1])
    );

    function automatic int lat_of(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    function automatic int nregs_of(input int d);
        return (d == 0) ? 32 : 16;
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic chk(input int d, input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL dut%0d %s observed=%0h expected=%0h", d, tag, obs, exp);
        end
    endtask

    // Idle-state outputs expected after reset or after a response is accepted.
    task automatic chk_idle(input int d, input string pfx);
        chk(d, {pfx, "_req_ready"},  req_ready[d],  1'b1);
        chk(d, {pfx, "_busy"},       busy[d],       1'b0);
        chk(d, {pfx, "_resp_valid"}, resp_valid[d], 1'b0);
        chk(d, {pfx, "_pcr_en"},     pcr_en[d],     1'b0);
    endtask

    // One complete transaction. Cycle 0 is the request-fire cycle; cycle k is
    // the cycle after the k-th following rising edge. Outputs are sampled on
    // the falling edge, then new (partly random) inputs are driven.
    task automatic txn(input int d, input bit rw, input logic [4:0] addr,
                       input logic [63:0] data, input logic [63:0] cap, input int hold);
        int          lat;
        bit          inr;
        int          exp_lat;
        int          last;
        logic [63:0] hist [16];
        logic [63:0] exp_data;
        lat     = lat_of(d);
        inr     = (int'(addr) < nregs_of(d));
        exp_lat = inr ? 2 + lat : 2;
        last    = exp_lat + hold + 1;
        @(negedge clk);
        chk(d, "req_ready_before", req_ready[d], 1'b1);
        req_valid[d]  = 1'b1;
        req_rw[d]     = rw;
        req_addr[d]   = addr;
        req_data[d]   = data;
        resp_ready[d] = 1'b0;
        hist[0]       = rnd64();
        pcr_rdata[d]  = hist[0];
        for (int k = 1; k <= last; k++) begin
            @(negedge clk);
            if (k == last) begin
                chk_idle(d, "post_resp");
                req_valid[d]  = 1'b0;
                resp_ready[d] = 1'b0;
            end else begin
                chk(d, "busy", busy[d], 1'b1);
                chk(d, "req_ready_busy", req_ready[d], 1'b0);
                chk(d, "pcr_en", pcr_en[d], (inr && k == 1));
                if (inr && k == 1) chk(d, "pcr_wen", pcr_wen[d], rw);
                chk(d, "pcr_addr", pcr_addr[d], addr);
                chk(d, "pcr_wdata", pcr_wdata[d], data);
                chk(d, "resp_valid", resp_valid[d], (k >= exp_lat));
                if (k >= exp_lat) begin
                    exp_data = !inr ? 64'd0 : (rw ? data : hist[1 + lat]);
                    chk(d, "resp_data", resp_data[d], exp_data);
                    chk(d, "resp_err", resp_err[d], !inr);
                end
                // Request-side inputs are scrambled; the bridge must ignore them.
                req_valid[d] = 1'($urandom);
                req_rw[d]    = 1'($urandom);
                req_addr[d]  = 5'($urandom);
                req_data[d]  = rnd64();
                if (k < exp_lat)            resp_ready[d] = 1'($urandom);
                else if (k < exp_lat + hold) resp_ready[d] = 1'b0;
                else                         resp_ready[d] = 1'b1;
                hist[k]      = (k == 1 + lat && cap != 64'd0) ? cap : rnd64();
                pcr_rdata[d] = hist[k];
            end
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; req_valid[d] = 1'b0; req_rw[d] = 1'b0; req_addr[d] = '0;
            req_data[d] = '0; resp_ready[d] = 1'b0; pcr_rdata[d] = '0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b0;
        end
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk_idle(d, "reset");
            chk(d, "reset_pcr_wen", pcr_wen[d], 1'b0);
            chk(d, "reset_err", resp_err[d], 1'b0);
            chk(d, "reset_resp_data", resp_data[d], 64'd0);
            chk(d, "reset_pcr_addr", pcr_addr[d], 5'd0);
            chk(d, "reset_pcr_wdata", pcr_wdata[d], 64'd0);
        end

        // Directed reads/writes, range boundaries and back-pressure
        txn(0, 1'b0, 5'd5,  64'h0,    64'h55,   0);
        txn(1, 1'b0, 5'd2,  64'h0,    64'hDEAD, 0);
        txn(0, 1'b1, 5'd0,  64'hA5,   64'h0,    0);
        txn(1, 1'b1, 5'd0,  64'hA5,   64'h0,    0);
        txn(1, 1'b0, 5'd20, 64'h0,    64'h0,    0);
        txn(1, 1'b0, 5'd15, 64'h0,    64'h1234, 1);
        txn(1, 1'b1, 5'd16, 64'hBEEF, 64'h0,    0);
        txn(0, 1'b0, 5'd31, 64'h0,    64'h77,   0);
        txn(0, 1'b0, 5'd9,  64'h0,    64'h99,   4);
        txn(1, 1'b1, 5'd3,  64'hC0DE, 64'h0,    4);

        // Reset during WAIT abandons the transaction
        @(negedge clk);
        req_valid[1] = 1'b1; req_rw[1] = 1'b0; req_addr[1] = 5'd2; req_data[1] = rnd64();
        @(negedge clk);
        req_valid[1] = 1'b0;
        chk(1, "rstwait_pcr_en", pcr_en[1], 1'b1);
        @(negedge clk);
        chk(1, "rstwait_busy", busy[1], 1'b1);
        rst[1] = 1'b1;
        @(negedge clk);
        rst[1] = 1'b0;
        chk_idle(1, "rstwait");
        chk(1, "rstwait_resp_data", resp_data[1], 64'd0);
        chk(1, "rstwait_err", resp_err[1], 1'b0);
        chk(1, "rstwait_pcr_addr", pcr_addr[1], 5'd0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk(1, "rstwait_quiet_en", pcr_en[1], 1'b0);
            chk(1, "rstwait_quiet_resp", resp_valid[1], 1'b0);
        end

        // Random transactions on both instances
        for (int i = 0; i < 30; i++) begin
            int d;
            d = i % 2;
            txn(d, 1'($urandom), 5'($urandom), rnd64(), 64'h0, int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/host_pcr_bridge.md
HOST_PCR_BRIDGE -- requirements
Module: host_pcr_bridge

Interface
REQ-001 SHALL have parameter READ_LAT, default 0, giving the cycles from PCR strobe to valid io_pcr_rdata (legal 0..7).
REQ-002 SHALL have parameter NUM_REGS, default 32, giving the number of implemented PCR addresses (legal 1..32).
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-005 SHALL have port io_req_valid, input, 1 bit, host request present.
REQ-006 SHALL have port io_req_ready, output, 1 bit, bridge accepts a request.
REQ-007 SHALL have port io_req_bits_rw, input, 1 bit, 1 = write, 0 = read.
REQ-008 SHALL have port io_req_bits_addr, input, 5 bits, PCR index.
REQ-009 SHALL have port io_req_bits_data, input, 64 bits, write data.
REQ-010 SHALL have port io_resp_valid, output, 1 bit, response present.
REQ-011 SHALL have port io_resp_ready, input, 1 bit, host accepts the response.
REQ-012 SHALL have port io_resp_bits_data, output, 64 bits, read data or echoed write data.
REQ-013 SHALL have port io_resp_bits_err, output, 1 bit, address out of range.
REQ-014 SHALL have port io_pcr_en, output, 1 bit, one-cycle access strobe to the PCR file.
REQ-015 SHALL have port io_pcr_wen, output, 1 bit, write qualifier, valid only with io_pcr_en.
REQ-016 SHALL have port io_pcr_addr, output, 5 bits, latched request address.
REQ-017 SHALL have port io_pcr_wdata, output, 64 bits, latched request data.
REQ-018 SHALL have port io_pcr_rdata, input, 64 bits, PCR file read data.
REQ-019 SHALL have port io_busy, output, 1 bit, high whenever the state is not IDLE.

Function
REQ-020 SHALL implement the four-state FSM IDLE, ISSUE, WAIT and RESP.
REQ-021 In IDLE, SHALL drive io_req_ready=1; on req fire (valid&&ready), SHALL latch rw, addr and data, then go to ISSUE; io_req_ready SHALL be 0 in all other states.
REQ-022 In ISSUE with addr<NUM_REGS, SHALL drive io_pcr_en=1 and io_pcr_wen=rw for exactly one cycle.
REQ-023 If READ_LAT=0, ISSUE SHALL go to RESP; otherwise ISSUE SHALL go to WAIT with a 3-bit counter loaded with READ_LAT-1.
REQ-024 In WAIT, the counter SHALL decrement each cycle; WAIT SHALL exit to RESP when the counter reaches 0.
REQ-025 For reads, SHALL capture io_pcr_rdata into the response register in the cycle that is READ_LAT cycles after the io_pcr_en cycle: ISSUE when READ_LAT=0, otherwise the final WAIT cycle.
REQ-026 For writes, SHALL load the response data with the latched write data.
REQ-027 In ISSUE with addr>=NUM_REGS, SHALL keep io_pcr_en=0, set err=1 and data=0, and go directly to RESP.
REQ-028 In RESP, SHALL hold io_resp_valid=1 with stable data and err until io_resp_ready=1, then go to IDLE.
REQ-029 SHALL NOT bypass IDLE: a new request SHALL be accepted no earlier than the cycle after resp fire.
REQ-030 Latency: SHALL assert io_resp_valid 2+READ_LAT cycles after req fire for in-range requests, and 2 cycles after req fire for out-of-range requests.
REQ-031 io_pcr_addr and io_pcr_wdata SHALL change only on req fire.
REQ-032 Request inputs SHALL be ignored in every state except IDLE.

Reset
REQ-033 During reset, SHALL set state=IDLE, the counter to 0 and the response register to 0.
REQ-034 After reset, outputs SHALL be io_req_ready=1, io_resp_valid=0, io_pcr_en=0, io_pcr_wen=0, io_busy=0, io_resp_bits_err=0, and pcr addr/wdata=0.
REQ-035 Reset asserted mid-transaction SHALL abandon it with no io_pcr_en pulse in the following cycle and no response.

Verification
REQ-036 READ_LAT=0: read addr 5 with rdata=0x55 -> io_pcr_en at cycle 1 with wen=0, resp_valid at cycle 2 with data=0x55 and err=0.
REQ-037 READ_LAT=3: read addr 2 with rdata=0xDEAD at cycle 4 -> resp_valid at cycle 5 with data=0xDEAD; io_busy=1 from cycle 1 through the resp fire cycle.
REQ-038 Write addr 0 with data 0xA5 -> one-cycle io_pcr_en=1 and wen=1 with wdata=0xA5, then resp data=0xA5.
REQ-039 NUM_REGS=16: read addr 20 -> io_pcr_en never asserted, resp at cycle 2 with err=1 and data=0.
REQ-040 Hold io_resp_ready=0 for 4 cycles -> resp stays valid and stable and io_req_ready=0; release it -> io_req_ready=1 the next cycle.
REQ-041 Assert reset during WAIT -> next cycle IDLE, io_resp_valid=0, and no io_pcr_en pulse.
